// File: rtl/counter_bounded.sv
// counter_bounded: bounded up/down counter with programmable step, runtime limit, wrap/saturate and flags
// Ports: clock, reset (async, active-low); enable gates all updates; count_up/count_down step by step;
// load takes load_value clamped to limit; limit is the inclusive top of range 0..limit; mode 0 wraps, 1 saturates;
// counter_value, overflow, underflow are registered; at_max, at_zero are combinational views of counter_value.
module counter_bounded #(
    parameter int WIDTH      = 8,
    parameter int STEP_WIDTH = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  count_up,
    input  logic                  count_down,
    input  logic                  load,
    input  logic [WIDTH-1:0]      load_value,
    input  logic [STEP_WIDTH-1:0] step,
    input  logic [WIDTH-1:0]      limit,
    input  logic                  mode,
    output logic [WIDTH-1:0]      counter_value,
    output logic                  at_max,
    output logic                  at_zero,
    output logic                  overflow,
    output logic                  underflow
);
    // Two guard bits: one for the carry past limit, one so a negative wrap-down result shows up as the msb.
    localparam int XW = WIDTH + 2;
    logic [XW-1:0] v_x, l_x, s_x, sum, up_wrap, dn_wrap;
    logic [WIDTH-1:0] nxt;
    logic ov_n, uf_n;
    assign v_x     = XW'(counter_value);
    assign l_x     = XW'(limit);
    assign s_x     = XW'(step);
    assign sum     = v_x + s_x;
    assign up_wrap = sum - l_x - 1'b1;
    assign dn_wrap = l_x + 1'b1 + v_x - s_x;
    always_comb begin
        nxt  = counter_value;
        ov_n = 1'b0;
        uf_n = 1'b0;
        if (enable && !load && counter_value > limit) begin
            nxt  = mode ? limit : '0;
            ov_n = 1'b1;
        end else if (enable && load) begin
            nxt = load_value > limit ? limit : load_value;
        end else if (enable && count_up && !count_down) begin
            ov_n = sum > l_x;
            nxt  = !ov_n ? WIDTH'(sum) : mode ? limit : up_wrap > l_x ? '0 : WIDTH'(up_wrap);
        end else if (enable && count_down && !count_up) begin
            uf_n = s_x > v_x;
            nxt  = !uf_n ? WIDTH'(v_x - s_x) : mode ? '0 : dn_wrap[XW-1] ? limit : WIDTH'(dn_wrap);
        end
    end
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            counter_value <= '0;
            overflow      <= 1'b0;
            underflow     <= 1'b0;
        end else begin
            counter_value <= nxt;
            overflow      <= ov_n;
            underflow     <= uf_n;
        end
    end
    assign at_max  = counter_value == limit;
    assign at_zero = counter_value == '0;
endmodule

// File: tb/tb_counter_bounded.sv
// tb_counter_bounded: directed vectors checked every cycle against an integer model of counter_bounded
module tb_counter_bounded;
    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b0, count_up = 1'b0, count_down = 1'b0, load = 1'b0, mode = 1'b0;
    logic [7:0] load_value = '0, limit = 8'hFF;
    logic [3:0] step = 4'd1;
    logic [7:0] counter_value;
    logic       at_max, at_zero, overflow, underflow;
    int  vectors = 0, miscompares = 0;
    int  mv = 0, v_m, l_m, s_m;
    bit  mo = 0, mu = 0;

    counter_bounded #(.WIDTH(8), .STEP_WIDTH(4)) dut (
        .clock(clock), .reset(reset), .enable(enable), .count_up(count_up), .count_down(count_down),
        .load(load), .load_value(load_value), .step(step), .limit(limit), .mode(mode),
        .counter_value(counter_value), .at_max(at_max), .at_zero(at_zero),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clock = ~clock;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            mv = 0; mo = 0; mu = 0;
        end else begin
            v_m = mv; l_m = int'(limit); s_m = int'(step);
            mo = 0; mu = 0;
            if (!enable) begin
                mv = v_m;
            end else if (v_m > l_m && !load) begin
                mv = mode ? l_m : 0; mo = 1;
            end else if (load) begin
                mv = int'(load_value) > l_m ? l_m : int'(load_value);
            end else if (count_up && !count_down) begin
                if (v_m + s_m <= l_m) mv = v_m + s_m;
                else begin
                    mo = 1;
                    mv = mode ? l_m : (v_m + s_m - (l_m + 1) > l_m ? 0 : v_m + s_m - (l_m + 1));
                end
            end else if (count_down && !count_up) begin
                if (s_m <= v_m) mv = v_m - s_m;
                else begin
                    mu = 1;
                    mv = mode ? 0 : (l_m + 1 + v_m - s_m < 0 ? l_m : l_m + 1 + v_m - s_m);
                end
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic compare_all;
        chk("counter_value", int'(counter_value), mv);
        chk("overflow", int'(overflow), int'(mo));
        chk("underflow", int'(underflow), int'(mu));
        chk("at_max", int'(at_max), int'(mv == int'(limit)));
        chk("at_zero", int'(at_zero), int'(mv == 0));
    endtask

    task automatic pin(input string nm, input int v, input bit o, input bit u);
        chk({nm, "_model"}, mv, v);
        chk({nm, "_value"}, int'(counter_value), v);
        chk({nm, "_overflow"}, int'(overflow), int'(o));
        chk({nm, "_underflow"}, int'(underflow), int'(u));
    endtask

    task automatic cyc(input bit en, input bit up, input bit dn, input bit ld,
                       input int lv, input int st, input int lim, input bit md);
        enable = en; count_up = up; count_down = dn; load = ld;
        load_value = 8'(lv); step = 4'(st); limit = 8'(lim); mode = md;
        @(negedge clock);
        compare_all();
    endtask

    initial begin
        @(negedge clock);
        compare_all();
        pin("reset", 0, 0, 0);
        reset = 1'b1;
        cyc(1, 0, 0, 1, 0, 1, 255, 0);
        for (int i = 0; i < 5; i++) cyc(1, 1, 0, 0, 0, 1, 255, 0);
        pin("count5", 5, 0, 0);
        #2 reset = 1'b0;
        #1 compare_all();
        pin("reset_mid", 0, 0, 0);
        chk("reset_mid_at_zero", int'(at_zero), 1);
        @(negedge clock);
        compare_all();
        reset = 1'b1;
        cyc(1, 0, 0, 1, 8, 1, 9, 0);
        cyc(1, 1, 0, 0, 0, 1, 9, 0);
        pin("wrap_to_max", 9, 0, 0);
        chk("wrap_to_max_at_max", int'(at_max), 1);
        cyc(1, 1, 0, 0, 0, 1, 9, 0);
        pin("wrap_up", 0, 1, 0);
        cyc(1, 0, 0, 0, 0, 1, 9, 0);
        pin("wrap_up_pulse_end", 0, 0, 0);
        cyc(1, 0, 0, 1, 7, 4, 9, 1);
        cyc(1, 1, 0, 0, 0, 4, 9, 1);
        pin("sat_up", 9, 1, 0);
        cyc(1, 1, 0, 0, 0, 4, 9, 1);
        pin("sat_up_again", 9, 1, 0);
        cyc(1, 0, 0, 1, 1, 3, 9, 1);
        cyc(1, 0, 1, 0, 0, 3, 9, 1);
        pin("sat_down", 0, 0, 1);
        cyc(1, 0, 0, 1, 1, 3, 9, 0);
        cyc(1, 0, 1, 0, 0, 3, 9, 0);
        pin("wrap_down", 8, 0, 1);
        cyc(1, 0, 0, 1, 0, 1, 255, 0);
        cyc(1, 0, 1, 0, 0, 1, 255, 0);
        pin("wrap_down_full", 255, 0, 1);
        cyc(1, 0, 0, 1, 'hDE, 1, 'h20, 0);
        pin("load_clamp", 'h20, 0, 0);
        cyc(1, 0, 0, 1, 'hDE, 1, 255, 0);
        cyc(1, 1, 0, 0, 0, 1, 255, 0);
        pin("full_up", 'hDF, 0, 0);
        cyc(1, 0, 0, 1, 'hFF, 1, 255, 0);
        cyc(1, 1, 0, 0, 0, 1, 255, 0);
        pin("full_wrap", 0, 1, 0);
        cyc(0, 0, 0, 1, 'h55, 1, 255, 0);
        pin("enable_low", 0, 0, 0);
        cyc(1, 0, 0, 1, 'h33, 1, 255, 0);
        cyc(1, 1, 1, 0, 0, 1, 255, 0);
        pin("up_and_down", 'h33, 0, 0);
        cyc(1, 1, 0, 0, 0, 0, 'h33, 1);
        pin("step0_at_max", 'h33, 0, 0);
        chk("step0_at_max_flag", int'(at_max), 1);
        cyc(1, 0, 0, 1, 'h10, 1, 255, 0);
        cyc(1, 0, 0, 0, 0, 1, 3, 0);
        pin("out_of_range_wrap", 0, 1, 0);
        cyc(1, 0, 0, 1, 'h10, 1, 255, 1);
        cyc(1, 0, 0, 0, 0, 1, 3, 1);
        pin("out_of_range_sat", 3, 1, 0);
        cyc(1, 0, 0, 1, 2, 15, 2, 0);
        cyc(1, 1, 0, 0, 0, 15, 2, 0);
        pin("wrap_up_excess", 0, 1, 0);
        cyc(1, 0, 1, 0, 0, 15, 2, 0);
        pin("wrap_down_negative", 2, 0, 1);
        cyc(1, 0, 1, 0, 0, 0, 2, 0);
        pin("step0_down", 2, 0, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/counter_bounded.md
# counter_bounded

Parametrised successor to the loadable up/down counter. Adds:

- a programmable step size;
- a runtime upper bound (`limit`);
- selectable wrap or saturate behaviour at the bounds;
- terminal-count flags and overflow/underflow pulses.

It is used for loop counters, circular-buffer pointers and bounded address generation in the processor datapath. All state is held in registers updated on the rising clock edge.

## Interface

Parameters:

- `WIDTH`, 8, counter, load and limit width in bits.
- `STEP_WIDTH`, 4, width of the step input.

Ports (one clock; reset is asynchronous and active-low):

- `clock`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset; low clears all state immediately.
- `enable`  in  1  high permits any state change; low holds everything.
- `count_up`  in  1  increment by `step`.
- `count_down`  in  1  decrement by `step`.
- `load`  in  1  load `load_value` (clamped to `limit`).
- `load_value`  in  `WIDTH`  value to load.
- `step`  in  `STEP_WIDTH`  increment/decrement magnitude, zero-extended; 0 means no change.
- `limit`  in  `WIDTH`  inclusive upper bound; the counting range is 0..`limit`.
- `mode`  in  1  0 = wrap (modulo `limit`+1), 1 = saturate.
- `counter_value`  out  `WIDTH`  registered count.
- `at_max`  out  1  combinational: `counter_value` == `limit`.
- `at_zero`  out  1  combinational: `counter_value` == 0.
- `overflow`  out  1  registered one-cycle pulse: the upper bound was crossed or clipped.
- `underflow`  out  1  registered one-cycle pulse: zero was crossed or clipped.

## Operation

Per-edge priority, highest first:

1. **Reset low:** `counter_value`=0, `overflow`=`underflow`=0.
2. **`enable`=0:** hold `counter_value`; flags cleared to 0.
3. **Out-of-range:** `counter_value` > `limit` (the limit was lowered at runtime). Applies on any enabled cycle without `load`.
   - Next value is 0 in wrap mode, `limit` in saturate mode.
   - `overflow`=1.
4. **`load`:** next value is `min(load_value, limit)`; flags 0.
5. **`count_up` and `count_down` both high:** hold; flags 0.
6. **`count_up`:**
   - Compute sum = value + step in `WIDTH`+1 bits.
   - sum ≤ `limit`: next value = sum.
   - sum > `limit`, wrap mode: next value = sum − (`limit`+1); if that result still exceeds `limit`, next value = 0. `overflow`=1.
   - sum > `limit`, saturate mode: next value = `limit`; `overflow`=1.
7. **`count_down`:**
   - step ≤ value: next value = value − step.
   - step > value, wrap mode: next value = `limit`+1+value−step in `WIDTH`+1 bits; if that is negative, next value = `limit`. `underflow`=1.
   - step > value, saturate mode: next value = 0; `underflow`=1.
8. **Otherwise:** hold; flags 0.

Additional rules:

- `step`=0 with `count_up` or `count_down`: hold, no flags. This holds even at a bound.
- `limit` = all-ones: the full range is used, and wrap arithmetic is modulo 2^`WIDTH` via the `WIDTH`+1 intermediate.
- A saturated counter that is pushed again at its bound pulses its flag again on every such cycle.

## Timing

- Latency: 1 cycle from the control inputs to `counter_value`, `overflow` and `underflow`.
- The flags update on the same edge as the value they describe.
- Flags are high for exactly one cycle per offending edge, and stay high on consecutive offending edges.
- `at_max` and `at_zero` follow `counter_value` and `limit` combinationally, with no extra latency.
- Reset assertion takes effect asynchronously, independent of `clock`.
  - While reset is low: `counter_value`=0, flags=0, `at_zero`=1, `at_max`=(`limit`==0).
- Reset release is synchronous to the next rising edge. The first update happens on the first edge after `reset` goes high.
- Reset asserted mid-count aborts the operation; no partial update is retained.

## Test plan

All scenarios use `WIDTH`=8 and `STEP_WIDTH`=4.

- **Reset mid-count:** count up to 5, then drive `reset` low between edges → `counter_value`=0 before the next edge; `overflow`=`underflow`=0; `at_zero`=1.
- **Wrap up:** `limit`=9, `mode`=0, `step`=1, load 8, then `count_up` for 2 cycles → 9 with `at_max`=1, then 0 with `overflow` high for exactly one cycle.
- **Saturate up and down:** `limit`=9, `mode`=1, value 7, `step`=4, up → 9 with `overflow`=1; up again → 9 with `overflow`=1. Then load 1, `step`=3, down → 0 with `underflow`=1.
- **Wrap down:** `limit`=9, `mode`=0, value 1, `step`=3, down → 8 with `underflow`=1. With `limit`=0xFF, value 0x00, `step`=1, down → 0xFF.
- **Load clamp and full range:** `limit`=0x20, load 0xDE → 0x20. Then `limit`=0xFF, load 0xDE, up `step`=1 → 0xDF. Then load 0xFF, up → 0x00 with `overflow`=1.
- **Priority:** `enable`=0 with `load`=1 → value unchanged. `count_up`=`count_down`=1 → hold. `step`=0 with up at `limit` → hold, no flag. Value 0x10, `limit` lowered to 3, `mode`=0, enabled idle → 0 with `overflow`=1.
